// File: rtl/ldst_pkg.sv
// ldst_pkg: shared widths, FSM state encoding and error codes for the LD/SD sequencer
package ldst_pkg;
    localparam int XLEN_DEF = 64;
    localparam int RAW_DEF  = 5;
    typedef enum logic [2:0] {IDLE, RREG, AGEN, MEM, FIN} state_t;
    typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_MISALIGN = 2'b01, ERR_TIMEOUT = 2'b10} err_t;
endpackage

// File: rtl/ldst_seq_if.sv
// ldst_seq_if: register-file and data-memory port bundle of the sequencer
//   rf_ra1/rf_rd1, rf_ra2/rf_rd2 : two combinational read ports
//   rf_we/rf_wa/rf_wd            : write port
//   mem_req/we/addr/wdata        : memory request, mem_ready/mem_rdata : completion
//   master = sequencer side, slave = register file / memory side
interface ldst_seq_if import ldst_pkg::*; #(parameter int XLEN = XLEN_DEF, parameter int RAW = RAW_DEF);
    logic [RAW-1:0]  rf_ra1, rf_ra2, rf_wa;
    logic [XLEN-1:0] rf_rd1, rf_rd2, rf_wd;
    logic            rf_we;
    logic            mem_req, mem_we, mem_ready;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    modport master (
        output rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_rd1, rf_rd2, mem_ready, mem_rdata
    );
    modport slave (
        input  rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, mem_req, mem_we, mem_addr, mem_wdata,
        output rf_rd1, rf_rd2, mem_ready, mem_rdata
    );
endinterface

// File: rtl/ldst_agen.sv
// ldst_agen: effective address base + offset (wraps silently) and doubleword misalignment flag
//   base, offset : operands;  addr : sum;  misalign : addr[2:0] != 0
module ldst_agen #(parameter int XLEN = 64) (
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] addr,
    output logic            misalign
);
    assign addr     = base + offset;
    assign misalign = |addr[2:0];
endmodule

// File: rtl/ldst_seq.sv
// ldst_seq: multi-cycle LD/SD sequencer, IDLE -> RREG -> AGEN -> MEM -> FIN
//   start/is_store/rs1/rs2_rd/offset : decoded op, sampled in IDLE
//   busy : not IDLE;  done : one-cycle completion;  err : result code while done
//   bus  : register file and data memory ports (master side)
module ldst_seq import ldst_pkg::*; #(
    parameter int XLEN     = XLEN_DEF,
    parameter int RAW      = RAW_DEF,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_store,
    input  logic [RAW-1:0]  rs1,
    input  logic [RAW-1:0]  rs2_rd,
    input  logic [XLEN-1:0] offset,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err,
    ldst_seq_if.master      bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    // Every output is a field of this register so the block is strictly Moore.
    typedef struct packed {
        state_t          st;
        logic            is_store;
        logic [XLEN-1:0] off, base, sdata;
        logic [WW-1:0]   wcnt;
        logic            busy, done;
        err_t            err;
        logic [RAW-1:0]  rf_ra1, rf_ra2, rf_wa;
        logic            rf_we;
        logic [XLEN-1:0] rf_wd;
        logic            mem_req, mem_we;
        logic [XLEN-1:0] mem_addr, mem_wdata;
    } regs_t;

    regs_t           q, n;
    logic [XLEN-1:0] addr;
    logic            misalign, wb;

    ldst_agen #(.XLEN(XLEN)) u_agen (.base(q.base), .offset(q.off), .addr(addr), .misalign(misalign));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= n;
    end

    always_comb begin
        n  = q;
        // rf_ra2 holds the latched rs2_rd, which is rd for loads.
        wb = bus.mem_ready && !q.is_store && q.rf_ra2 != '0;
        case (q.st)
            IDLE: if (start) begin
                n.st       = RREG;
                n.busy     = 1'b1;
                n.is_store = is_store;
                n.rf_ra1   = rs1;
                n.rf_ra2   = rs2_rd;
                n.off      = offset;
            end
            RREG: begin
                n.st    = AGEN;
                n.base  = bus.rf_rd1;
                n.sdata = bus.rf_rd2;
            end
            AGEN: if (misalign) begin
                n.st   = FIN;
                n.done = 1'b1;
                n.err  = ERR_MISALIGN;
            end else begin
                n.st        = MEM;
                n.mem_req   = 1'b1;
                n.mem_we    = q.is_store;
                n.mem_addr  = addr;
                n.mem_wdata = q.is_store ? q.sdata : '0;
                n.wcnt      = '0;
            end
            // ready on the last allowed cycle still wins over the timeout
            MEM: if (bus.mem_ready || q.wcnt == WW'(MAX_WAIT)) begin
                n.st        = FIN;
                n.done      = 1'b1;
                n.err       = bus.mem_ready ? ERR_OK : ERR_TIMEOUT;
                n.mem_req   = 1'b0;
                n.mem_we    = 1'b0;
                n.mem_addr  = '0;
                n.mem_wdata = '0;
                n.rf_we     = wb;
                n.rf_wa     = wb ? q.rf_ra2 : '0;
                n.rf_wd     = wb ? bus.mem_rdata : '0;
            end else begin
                n.wcnt = q.wcnt + 1'b1;
            end
            FIN: begin
                n.st    = IDLE;
                n.busy  = 1'b0;
                n.done  = 1'b0;
                n.err   = ERR_OK;
                n.rf_we = 1'b0;
                n.rf_wa = '0;
                n.rf_wd = '0;
            end
            default: n.st = IDLE;
        endcase
    end

    assign busy          = q.busy;
    assign done          = q.done;
    assign err           = q.err;
    assign bus.rf_ra1    = q.rf_ra1;
    assign bus.rf_ra2    = q.rf_ra2;
    assign bus.rf_we     = q.rf_we;
    assign bus.rf_wa     = q.rf_wa;
    assign bus.rf_wd     = q.rf_wd;
    assign bus.mem_req   = q.mem_req;
    assign bus.mem_we    = q.mem_we;
    assign bus.mem_addr  = q.mem_addr;
    assign bus.mem_wdata = q.mem_wdata;
endmodule

// File: tb/tb_ldst_seq.sv
// tb_ldst_seq: directed self-checking bench for ldst_seq with a register file and memory model
module tb_ldst_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, is_store, busy, done;
    logic [4:0]  rs1, rs2_rd;
    logic [63:0] offset;
    logic [1:0]  err;
    logic [63:0] rf [32];
    int          total = 0, bad = 0;
    int          req_n, we_n, cyc, extra;
    logic        stable, w0;
    logic [63:0] a0, d0;

    ldst_seq_if #(.XLEN(64), .RAW(5)) bus ();

    ldst_seq #(.XLEN(64), .RAW(5), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .rs1(rs1),
        .rs2_rd(rs2_rd), .offset(offset), .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.rf_rd1 = rf[bus.rf_ra1];
    assign bus.rf_rd2 = rf[bus.rf_ra2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic s, input logic [4:0] a, input logic [4:0] b, input logic [63:0] o);
        start = 1'b1; is_store = s; rs1 = a; rs2_rd = b; offset = o;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples each negedge until done; answers mem_req after wait_n stalled cycles.
    task automatic run(input int wait_n, input int budget, input bit pulse, output int c);
        c = 1; req_n = 0; we_n = 0; stable = 1'b1;
        forever begin
            if (bus.mem_req) begin
                req_n++;
                if (req_n == 1) begin a0 = bus.mem_addr; w0 = bus.mem_we; d0 = bus.mem_wdata; end
                else if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {a0, w0, d0}) stable = 1'b0;
            end
            if (bus.rf_we) we_n++;
            bus.mem_ready = bus.mem_req && req_n == wait_n + 1;
            start = pulse && req_n == 2;
            if (done || c >= budget) break;
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; rs1 = '0; rs2_rd = '0; offset = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
        rf[0] = '0; rf[2] = 64'h100; rf[7] = 64'h1234; rf[3] = 64'hFFFF_FFFF_FFFF_FFF8;
        #3;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        chk("rst_req", bus.mem_req, 0); chk("rst_rfwe", bus.rf_we, 0); chk("rst_addr", bus.mem_addr, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        bus.mem_rdata = 64'hDEADBEEF;
        issue(0, 2, 6, 64'd8); run(0, 40, 0, cyc);
        chk("t1_lat", cyc, 4); chk("t1_addr", a0, 64'h108); chk("t1_we", w0, 0); chk("t1_reqn", req_n, 1);
        chk("t1_rfwe", bus.rf_we, 1); chk("t1_rfwa", bus.rf_wa, 6); chk("t1_rfwd", bus.rf_wd, 64'hDEADBEEF);
        chk("t1_err", err, 0); chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_drop", {busy, done, bus.rf_we}, 0);

        issue(0, 2, 6, 64'd6); run(0, 40, 0, cyc);
        chk("t3_lat", cyc, 3); chk("t3_err", err, 1); chk("t3_reqn", req_n, 0); chk("t3_wen", we_n, 0);
        @(negedge clk);
        chk("t3_errclr", err, 0);

        rf[2] = 64'h200;
        issue(1, 2, 7, -64'sd16); run(3, 40, 0, cyc);
        chk("t2_lat", cyc, 7); chk("t2_reqn", req_n, 4); chk("t2_stable", stable, 1);
        chk("t2_addr", a0, 64'h1F0); chk("t2_we", w0, 1); chk("t2_wdata", d0, 64'h1234);
        chk("t2_wen", we_n, 0); chk("t2_err", err, 0);
        @(negedge clk);

        bus.mem_rdata = 64'h55AA;
        issue(0, 3, 5, 64'd16); run(0, 40, 0, cyc);
        chk("wrap_lat", cyc, 4); chk("wrap_addr", a0, 64'h8); chk("wrap_err", err, 0);
        chk("wrap_rfwa", bus.rf_wa, 5); chk("wrap_rfwd", bus.rf_wd, 64'h55AA);
        @(negedge clk);

        issue(0, 2, 8, 64'd0); run(1000, 60, 0, cyc);
        chk("to_lat", cyc, 19); chk("to_reqn", req_n, 16); chk("to_err", err, 2); chk("to_wen", we_n, 0);
        @(negedge clk);

        bus.mem_rdata = 64'h77;
        issue(0, 2, 8, 64'd0); run(15, 60, 0, cyc);
        chk("last_lat", cyc, 19); chk("last_reqn", req_n, 16); chk("last_err", err, 0);
        chk("last_rfwe", bus.rf_we, 1); chk("last_rfwd", bus.rf_wd, 64'h77);
        @(negedge clk);

        issue(0, 2, 0, 64'd0); run(0, 40, 0, cyc);
        chk("x0_done", done, 1); chk("x0_wen", we_n, 0); chk("x0_err", err, 0);
        @(negedge clk);

        issue(0, 2, 9, 64'd8); run(3, 40, 1, cyc);
        chk("pulse_lat", cyc, 7); chk("pulse_reqn", req_n, 4); chk("pulse_rfwa", bus.rf_wa, 9);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("pulse_noqueue", extra, 0);

        bus.mem_ready = 1'b0;
        issue(0, 2, 10, 64'd0);
        @(negedge clk); @(negedge clk);
        chk("r6_req", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r6_req0", bus.mem_req, 0); chk("r6_busy0", busy, 0); chk("r6_addr0", bus.mem_addr, 0);
        chk("r6_ra0", bus.rf_ra1, 0); chk("r6_done0", done, 0);
        @(negedge clk);
        chk("r6_nodone", {done, bus.rf_we}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rdata = 64'hABC;
        issue(0, 2, 11, 64'd8); run(0, 40, 0, cyc);
        chk("r6_lat", cyc, 4); chk("r6_addr", a0, 64'h208); chk("r6_rfwa", bus.rf_wa, 11);
        chk("r6_rfwd", bus.rf_wd, 64'hABC);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
